// File: rtl/board_io_pkg.sv
// Shared types and helpers for board I/O conditioning.
// Holds the key-reset FSM states and a ms-to-cycles helper.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    ACTIVE = 2'd2
  } rst_state_e;

  function automatic int ms_to_cycles(
    input int clk_mhz,
    input int ms
  );
    return clk_mhz * 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single key channel: 2-flop synchroniser, debounce counter,
// stable level and one-cycle press/release pulses.
module key_debouncer #(
  parameter int debounce_cycles = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int CW = $clog2(debounce_cycles + 1);
  localparam logic [CW-1:0] LAST = CW'(debounce_cycles - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          released_q, released_d;

  // Count cycles of disagreement; accept once the count completes.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    stable_d   = stable_q;
    cnt_d      = '0;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d   = sync2_q;
        pressed_d  = sync2_q;
        released_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers, all cleared to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      cnt_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign level    = stable_q;
  assign pressed  = pressed_q;
  assign released = released_q;

endmodule

// File: rtl/board_key_conditioner.sv
// Board key front end: per-key debounce plus a reset request
// raised by holding a key combination.
module board_key_conditioner
  import board_io_pkg::*;
#(
  parameter int clk_mhz            = 27,
  parameter int w_key              = 2,
  parameter int key_active_low     = 1,
  parameter int reverse_key        = 0,
  parameter int debounce_cycles    = ms_to_cycles(clk_mhz, 10),
  parameter logic [w_key-1:0] rst_key_mask = '1,
  parameter int rst_hold_cycles    = ms_to_cycles(clk_mhz, 500),
  parameter int rst_stretch_cycles = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [w_key-1:0] KEY,
  output logic [w_key-1:0] key,
  output logic [w_key-1:0] key_pressed,
  output logic [w_key-1:0] key_released,
  output logic             rst_out
);

  localparam int HW = $clog2(rst_hold_cycles + 1);
  localparam int SW = $clog2(rst_stretch_cycles + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(rst_hold_cycles - 1);
  localparam logic [SW-1:0] SLOAD = SW'(rst_stretch_cycles);

  logic [w_key-1:0] norm;

  for (genvar i = 0; i < w_key; i++) begin : g_ch
    localparam int SRC = (reverse_key != 0) ? (w_key - 1 - i) : i;
    assign norm[i] = KEY[SRC] ^ (key_active_low != 0);
    key_debouncer #(
      .debounce_cycles(debounce_cycles)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .raw      (norm[i]),
      .level    (key[i]),
      .pressed  (key_pressed[i]),
      .released (key_released[i])
    );
  end

  rst_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          rst_out_q, rst_out_d;
  logic          combo;

  assign combo = (rst_key_mask != '0) &&
                 ((key & rst_key_mask) == rst_key_mask);

  // Reset request FSM: hold the combination, then stretch after release.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stretch_d = stretch_q;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (combo) begin
          if (rst_hold_cycles == 1) begin
            state_d   = ACTIVE;
            stretch_d = SLOAD;
          end else begin
            state_d = HOLD;
            hold_d  = HW'(1);
          end
        end
      end
      HOLD: begin
        if (!combo) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = ACTIVE;
          hold_d    = '0;
          stretch_d = SLOAD;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ACTIVE: begin
        if (combo) begin
          stretch_d = SLOAD;
        end else if (stretch_q <= SW'(1)) begin
          state_d   = IDLE;
          stretch_d = '0;
        end else begin
          stretch_d = stretch_q - SW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        hold_d    = '0;
        stretch_d = '0;
      end
    endcase
    rst_out_d = rst | (state_q == ACTIVE);
  end

  // FSM and registered reset output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      stretch_q <= '0;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      stretch_q <= stretch_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign rst_out = rst_out_q;

endmodule

// File: tb/tb_board_key_conditioner.sv
// Directed bench for board_key_conditioner with a per-cycle
// expectation queue covering debounce, reversal and key reset.
module tb_board_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] KEY;
  logic [1:0] key, key_pressed, key_released;
  logic       rst_out;
  logic [1:0] key_r, kp_r, kr_r;
  logic       ro_r;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [6:0] vec;
    logic [1:0] krev;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  board_key_conditioner #(
    .clk_mhz(1), .w_key(2), .key_active_low(1),
    .reverse_key(0), .debounce_cycles(8),
    .rst_hold_cycles(20), .rst_stretch_cycles(4)
  ) dut (
    .clk(clk), .rst(rst), .KEY(KEY),
    .key(key), .key_pressed(key_pressed),
    .key_released(key_released), .rst_out(rst_out)
  );

  board_key_conditioner #(
    .clk_mhz(1), .w_key(2), .key_active_low(1),
    .reverse_key(1), .debounce_cycles(8),
    .rst_hold_cycles(20), .rst_stretch_cycles(4)
  ) dut_r (
    .clk(clk), .rst(rst), .KEY(KEY),
    .key(key_r), .key_pressed(kp_r),
    .key_released(kr_r), .rst_out(ro_r)
  );

  task automatic cyc(
    input string      tag,
    input logic [1:0] k,
    input logic [1:0] p,
    input logic [1:0] r,
    input logic       ro
  );
    exp_t e;
    exp_t x;
    e.tag  = tag;
    e.vec  = {k, p, r, ro};
    e.krev = {k[0], k[1]};
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_chk++;
    assert ({key, key_pressed, key_released, rst_out} === x.vec)
    else begin
      n_fail++;
      $error("FAIL %s: key/pr/rl/rst_out got %b expected %b",
             x.tag, {key, key_pressed, key_released, rst_out}, x.vec);
    end
    n_chk++;
    assert (key_r === x.krev)
    else begin
      n_fail++;
      $error("FAIL %s_rev: key got %b expected %b",
             x.tag, key_r, x.krev);
    end
  endtask

  initial begin
    rst = 1'b1;
    KEY = 2'b11;
    for (int n = 0; n < 3; n++) cyc("reset", 2'b00, 2'b00, 2'b00, 1'b1);
    rst = 1'b0;
    cyc("rst_rel", 2'b00, 2'b00, 2'b00, 1'b0);
    for (int n = 0; n < 3; n++) cyc("idle", 2'b00, 2'b00, 2'b00, 1'b0);

    KEY = 2'b10;
    for (int n = 1; n <= 20; n++)
      cyc("press0", (n >= 10) ? 2'b01 : 2'b00,
          (n == 10) ? 2'b01 : 2'b00, 2'b00, 1'b0);
    KEY = 2'b11;
    for (int n = 1; n <= 12; n++)
      cyc("rel0", (n < 10) ? 2'b01 : 2'b00, 2'b00,
          (n == 10) ? 2'b01 : 2'b00, 1'b0);

    KEY = 2'b10;
    for (int n = 1; n <= 5; n++) cyc("glitch", 2'b00, 2'b00, 2'b00, 1'b0);
    KEY = 2'b11;
    for (int n = 1; n <= 12; n++) cyc("glitch_end", 2'b00, 2'b00, 2'b00, 1'b0);

    KEY = 2'b01;
    for (int n = 1; n <= 14; n++)
      cyc("press1", (n >= 10) ? 2'b10 : 2'b00,
          (n == 10) ? 2'b10 : 2'b00, 2'b00, 1'b0);
    KEY = 2'b11;
    for (int n = 1; n <= 12; n++)
      cyc("rel1", (n < 10) ? 2'b10 : 2'b00, 2'b00,
          (n == 10) ? 2'b10 : 2'b00, 1'b0);

    KEY = 2'b00;
    for (int n = 1; n <= 40; n++)
      cyc("combo_hold", (n >= 10) ? 2'b11 : 2'b00,
          (n == 10) ? 2'b11 : 2'b00, 2'b00, n >= 31);
    KEY = 2'b11;
    for (int n = 41; n <= 60; n++)
      cyc("combo_rel", (n < 50) ? 2'b11 : 2'b00, 2'b00,
          (n == 50) ? 2'b11 : 2'b00, n <= 54);

    KEY = 2'b00;
    for (int n = 1; n <= 15; n++)
      cyc("short_hold", (n >= 10) ? 2'b11 : 2'b00,
          (n == 10) ? 2'b11 : 2'b00, 2'b00, 1'b0);
    KEY = 2'b11;
    for (int n = 16; n <= 35; n++)
      cyc("short_rel", (n < 25) ? 2'b11 : 2'b00, 2'b00,
          (n == 25) ? 2'b11 : 2'b00, 1'b0);

    KEY = 2'b10;
    for (int n = 1; n <= 5; n++) cyc("pre_rst", 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    cyc("mid_rst", 2'b00, 2'b00, 2'b00, 1'b1);
    rst = 1'b0;
    for (int m = 1; m <= 14; m++)
      cyc("re_accept", (m >= 10) ? 2'b01 : 2'b00,
          (m == 10) ? 2'b01 : 2'b00, 2'b00, 1'b0);
    KEY = 2'b11;
    for (int n = 1; n <= 12; n++)
      cyc("final_rel", (n < 10) ? 2'b01 : 2'b00, 2'b00,
          (n == 10) ? 2'b01 : 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_key_conditioner.md
BOARD_KEY_CONDITIONER -- requirements
Module: board_key_conditioner

Interface
REQ-001 The module SHALL have parameter clk_mhz, default 27, meaning system clock frequency in MHz.
REQ-002 The module SHALL have parameter w_key, default 2, meaning number of physical keys (1..32).
REQ-003 The module SHALL have parameter key_active_low, default 1, meaning 1 if a raw KEY bit reads 0 when pressed.
REQ-004 The module SHALL have parameter reverse_key, default 0, meaning 1 to map output bit i from raw bit w_key-1-i.
REQ-005 The module SHALL have parameter debounce_cycles, default clk_mhz*10000 (10 ms), meaning the stable-input time required to accept a change (>=1).
REQ-006 The module SHALL have parameter rst_key_mask, default all ones (w_key bits), meaning the key combination that requests reset; 0 disables key reset.
REQ-007 The module SHALL have parameter rst_hold_cycles, default clk_mhz*500000 (0.5 s), meaning how long the combination must be held (>=1).
REQ-008 The module SHALL have parameter rst_stretch_cycles, default 16, meaning the rst_out extension after the combination is released (>=1).
REQ-009 The module SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-010 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high (typically from imitate_reset_on_power_up).
REQ-011 The module SHALL have port KEY, input, w_key bits: raw asynchronous board keys.
REQ-012 The module SHALL have port key, output, w_key bits: debounced, active-high, optionally reversed key levels.
REQ-013 The module SHALL have port key_pressed, output, w_key bits: one-cycle pulse on each accepted 0->1 transition of key.
REQ-014 The module SHALL have port key_released, output, w_key bits: one-cycle pulse on each accepted 1->0 transition of key.
REQ-015 The module SHALL have port rst_out, output, 1 bit: board reset for lab_top and peripherals.

Function
REQ-016 Each raw bit SHALL be normalised to active-high (XOR with key_active_low), reordered per reverse_key, then passed through a 2-flop synchroniser.
REQ-017 Each channel SHALL keep a stable level and a counter of width $clog2(debounce_cycles+1).
REQ-018 The counter SHALL clear whenever the synchronised value equals the stable level; otherwise it SHALL increment each cycle.
REQ-019 When the counter reaches debounce_cycles-1 while the value still differs, the stable level SHALL flip, the matching pulse SHALL assert for exactly that one cycle, and the counter SHALL clear.
REQ-020 A glitch shorter than debounce_cycles SHALL produce no change and no pulse; a bounce restarts the count from 0.
REQ-021 Latency from a raw edge to the key change SHALL be exactly 2 + debounce_cycles cycles.
REQ-022 key_pressed and key_released SHALL never assert together on the same bit.
REQ-023 Channels SHALL be independent; simultaneous changes on several bits SHALL each pulse in their own cycle of acceptance.
REQ-024 Reset FSM states SHALL be IDLE, HOLD and ACTIVE.
REQ-025 IDLE->HOLD SHALL occur when rst_key_mask != 0 and (key & rst_key_mask) == rst_key_mask.
REQ-026 In HOLD, a hold counter SHALL count; HOLD->ACTIVE SHALL occur after rst_hold_cycles consecutive cycles of the combination; loss of the combination SHALL return HOLD->IDLE with the counter cleared.
REQ-027 In ACTIVE, a stretch counter SHALL reload to rst_stretch_cycles while the combination is held, decrement otherwise, and ACTIVE->IDLE SHALL occur when it reaches 0.
REQ-028 rst_out SHALL equal rst OR (state == ACTIVE), registered one cycle; keys outside rst_key_mask SHALL not affect the FSM.
REQ-029 rst_out SHALL not reset this module; only rst does.

Reset
REQ-030 While rst is high: synchronisers, stable levels and counters SHALL be 0 (released); key, key_pressed and key_released SHALL be 0; the FSM SHALL be IDLE; rst_out SHALL be 1 on the following cycle.
REQ-031 rst asserted mid-debounce or mid-hold SHALL abort the operation with no pulse; a key held through reset SHALL be accepted as a fresh press debounce_cycles+2 cycles after release of rst.

Structure
REQ-032 A shared package board_io_pkg SHALL hold the FSM state enum and the function ms_to_cycles(clk_mhz, ms).
REQ-033 A single-channel sub-module key_debouncer (synchroniser, counter, stable level, pulses) SHALL be generated w_key times; the reset FSM SHALL reside in the top of the block.

Verification (bench: clk_mhz=1, w_key=2, key_active_low=1, debounce_cycles=8, rst_hold_cycles=20, rst_stretch_cycles=4)
REQ-034 Bench SHALL drive KEY=2'b11->2'b10 held 20 cycles and require key=2'b01 exactly 10 cycles after the edge and key_pressed=2'b01 for one cycle.
REQ-035 Bench SHALL toggle KEY[0] low for 5 cycles, then high, and require no change on key or the pulses.
REQ-036 Bench SHALL apply reverse_key=1 with KEY[1] pressed and require key=2'b01.
REQ-037 Bench SHALL hold both keys pressed for 40 cycles and require rst_out high from cycle 10+20+1 until 4+1 cycles after the debounced release.
REQ-038 Bench SHALL hold both keys pressed for 15 cycles only and require rst_out to stay 0.
REQ-039 Bench SHALL pulse rst for 1 cycle mid-debounce and require all outputs 0, rst_out 1 for one cycle, and no press pulse until a full 10-cycle re-acceptance.
